impulse_frame_receiver: RTL and testbench

Host-side receiver for the serial readout stream produced by the multi-channel impulse counter. It deserializes counter words framed by the shift/load strobe and the 4-bit channel address, checks framing, and publishes each word with its channel. It also keeps a last-value bank for channels 1..8 and sticky overflow flags. The block sits on the FPGA/test-board side, clocked synchronously with the counter's `clk`.

---
 rtl/impulse_frame_receiver_if.sv | 41 ++++
 rtl/impulse_frame_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_impulse_frame_receiver.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/impulse_frame_receiver_if.sv
// Bus interface for impulse_frame_receiver.
// Groups the serial readout inputs, the word/error outputs, the bank read
// port and the sticky-flag controls. clk and reset stay outside as plain ports.
//   master : host side / stimulus (drives serial_in, sl_in, addr_in, flags,
//            rd_ch, clr_fresh; observes the rest)
//   slave  : the receiver itself
interface impulse_frame_receiver_if #(
    parameter int COUNT_W = 16,
    parameter int NUM_CH  = 8
);
    logic               serial_in;
    logic               sl_in;
    logic [3:0]         addr_in;
    logic               ovf_global_in;
    logic               ovf_rtc_in;
    logic [COUNT_W-1:0] word_out;
    logic [3:0]         ch_out;
    logic               word_valid;
    logic               frame_err;
    logic               overrun_err;
    logic [2:0]         rd_ch;
    logic [COUNT_W-1:0] rd_data;
    logic [NUM_CH-1:0]  ch_fresh;
    logic               clr_fresh;
    logic               ovf_global_sticky;
    logic               ovf_rtc_sticky;

    modport master (
        output serial_in, sl_in, addr_in, ovf_global_in, ovf_rtc_in,
        output rd_ch, clr_fresh,
        input  word_out, ch_out, word_valid, frame_err, overrun_err,
        input  rd_data, ch_fresh, ovf_global_sticky, ovf_rtc_sticky
    );

    modport slave (
        input  serial_in, sl_in, addr_in, ovf_global_in, ovf_rtc_in,
        input  rd_ch, clr_fresh,
        output word_out, ch_out, word_valid, frame_err, overrun_err,
        output rd_data, ch_fresh, ovf_global_sticky, ovf_rtc_sticky
    );
endinterface

// File: rtl/impulse_frame_receiver.sv
// impulse_frame_receiver
// Deserializes counter words (MSB first) framed by sl_in and a constant
// 4-bit channel address, publishes each word with its channel, keeps a
// last-value bank for channels 1..NUM_CH and sticky overflow flags.
// Ports:
//   clk    : system clock, rising-edge sampling
//   reset  : asynchronous, active-high
//   bus    : impulse_frame_receiver_if.slave (serial input, word/error
//            pulses, bank read port, fresh/sticky flags)
module impulse_frame_receiver #(
    parameter int COUNT_W = 16,
    parameter int NUM_CH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    impulse_frame_receiver_if.slave  bus
);
    localparam int             CNT_W    = $clog2(COUNT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_W - 1);
    localparam logic [4:0]     NUM_CH_L = 5'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD} state_t;

    state_t             r_state, w_state_next;
    logic [COUNT_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_addr;
    logic               r_ovr_armed;

    logic [COUNT_W-1:0] r_word_out;
    logic [3:0]         r_ch_out;
    logic               r_word_valid;
    logic               r_frame_err;
    logic               r_overrun_err;
    logic [COUNT_W-1:0] r_bank [NUM_CH];
    logic [NUM_CH-1:0]  r_ch_fresh;
    logic               r_ovf_global;
    logic               r_ovf_rtc;

    logic               w_start;
    logic               w_shift;
    logic               w_done;
    logic               w_ferr;
    logic               w_oerr;
    logic               w_addr_ok;
    logic               w_wr_en;
    logic [3:0]         w_wr_idx;
    logic [COUNT_W-1:0] w_shift_next;
    logic [COUNT_W-1:0] w_rd_data;

    assign w_shift_next = {r_shift[COUNT_W-2:0], bus.serial_in};
    assign w_addr_ok    = (r_addr != 4'd0) && ({1'b0, r_addr} <= NUM_CH_L);
    assign w_wr_en      = w_done && w_addr_ok;
    assign w_wr_idx     = r_addr - 4'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
        w_oerr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sl_in) begin
                    w_start      = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (!bus.sl_in) begin
                    w_ferr       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (bus.addr_in != r_addr) begin
                    // Address glitch mid-frame: drop the frame and wait
                    // for sl_in to fall before accepting a new one.
                    w_ferr       = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_done       = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!bus.sl_in) begin
                    w_state_next = S_IDLE;
                end else if (r_ovr_armed) begin
                    w_oerr = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Deserializer, output registers and pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_ovr_armed   <= 1'b0;
            r_word_out    <= '0;
            r_ch_out      <= '0;
            r_word_valid  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_word_valid  <= w_done;
            r_frame_err   <= w_ferr || (w_done && !w_addr_ok);
            r_overrun_err <= w_oerr;

            if (w_start) begin
                r_shift <= COUNT_W'(bus.serial_in);
                r_cnt   <= CNT_W'(1);
                r_addr  <= bus.addr_in;
            end else if (w_done || w_ferr) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else if (w_shift) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + 1'b1;
            end

            if (w_done) begin
                r_word_out <= w_shift_next;
                r_ch_out   <= r_addr;
            end

            // Overrun is only reported after a completed word, once.
            if (w_done) begin
                r_ovr_armed <= 1'b1;
            end else if (w_oerr || w_ferr || r_state == S_IDLE) begin
                r_ovr_armed <= 1'b0;
            end
        end
    end

    // Bank, fresh flags and sticky overflow flags; a set beats clr_fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_bank[i] <= '0;
            end
            r_ch_fresh   <= '0;
            r_ovf_global <= 1'b0;
            r_ovf_rtc    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (w_wr_en && (w_wr_idx == 4'(i))) begin
                    r_bank[i]     <= w_shift_next;
                    r_ch_fresh[i] <= 1'b1;
                end else if (bus.clr_fresh) begin
                    r_ch_fresh[i] <= 1'b0;
                end
            end

            if (bus.ovf_global_in) begin
                r_ovf_global <= 1'b1;
            end else if (bus.clr_fresh) begin
                r_ovf_global <= 1'b0;
            end

            if (bus.ovf_rtc_in) begin
                r_ovf_rtc <= 1'b1;
            end else if (bus.clr_fresh) begin
                r_ovf_rtc <= 1'b0;
            end
        end
    end

    // Combinational bank read; indices beyond the bank read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (i < 8 && bus.rd_ch == 3'(i)) begin
                w_rd_data = r_bank[i];
            end
        end
    end

    assign bus.word_out          = r_word_out;
    assign bus.ch_out            = r_ch_out;
    assign bus.word_valid        = r_word_valid;
    assign bus.frame_err         = r_frame_err;
    assign bus.overrun_err       = r_overrun_err;
    assign bus.rd_data           = w_rd_data;
    assign bus.ch_fresh          = r_ch_fresh;
    assign bus.ovf_global_sticky = r_ovf_global;
    assign bus.ovf_rtc_sticky    = r_ovf_rtc;

endmodule

// File: tb/tb_impulse_frame_receiver.sv
module tb_impulse_frame_receiver;
    localparam int CW = 16;
    localparam int NC = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    impulse_frame_receiver_if #(.COUNT_W(CW), .NUM_CH(NC)) bus ();

    impulse_frame_receiver #(.COUNT_W(CW), .NUM_CH(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          wv;
        logic          fe;
        logic          oe;
        logic [CW-1:0] word;
        logic [3:0]    ch;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic wv, input logic fe, input logic oe,
                        input logic [CW-1:0] word, input logic [3:0] ch);
        ev_t e;
        e.wv = wv; e.fe = fe; e.oe = oe; e.word = word; e.ch = ch;
        exp_q.push_back(e);
    endtask

    // Drive n bits of frame; bits past the word length send 0.
    task automatic drive_bits(input logic [3:0] addr, input logic [CW-1:0] w,
                              input int n, input bit clr_on_last);
        logic [CW-1:0] wv;
        wv = w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sl_in     = 1'b1;
            bus.addr_in   = addr;
            bus.serial_in = (i < CW) ? wv[CW-1-i] : 1'b0;
            bus.clr_fresh = (clr_on_last && i == n - 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.sl_in     = 1'b0;
            bus.serial_in = 1'b0;
            bus.clr_fresh = 1'b0;
        end
    endtask

    task automatic read_bank(input logic [2:0] idx, input logic [CW-1:0] req, input string name);
        bus.rd_ch = idx;
        #1;
        check(name, 32'(bus.rd_data), 32'(req));
    endtask

    // Monitor: every pulse must match the next expected event in order.
    initial begin
        ev_t e;
        bit  ok;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (bus.word_valid || bus.frame_err || bus.overrun_err)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: got wv=%b fe=%b oe=%b word=%h ch=%0d required none",
                             bus.word_valid, bus.frame_err, bus.overrun_err, bus.word_out, bus.ch_out);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (bus.word_valid === e.wv) && (bus.frame_err === e.fe) &&
                         (bus.overrun_err === e.oe) &&
                         (!e.wv || (bus.word_out === e.word && bus.ch_out === e.ch));
                    if (!ok) begin
                        n_errors++;
                        $display("FAIL event: got wv=%b fe=%b oe=%b word=%h ch=%0d required wv=%b fe=%b oe=%b word=%h ch=%0d",
                                 bus.word_valid, bus.frame_err, bus.overrun_err, bus.word_out, bus.ch_out,
                                 e.wv, e.fe, e.oe, e.word, e.ch);
                    end
                end
            end
        end
    end

    initial begin
        reset             = 1'b1;
        bus.serial_in     = 1'b0;
        bus.sl_in         = 1'b0;
        bus.addr_in       = 4'd0;
        bus.ovf_global_in = 1'b0;
        bus.ovf_rtc_in    = 1'b0;
        bus.rd_ch         = 3'd0;
        bus.clr_fresh     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_word_out", 32'(bus.word_out), 32'h0);
        check("rst_ch_out", 32'(bus.ch_out), 32'h0);
        check("rst_pulses", 32'({bus.word_valid, bus.frame_err, bus.overrun_err}), 32'h0);
        check("rst_fresh_sticky", 32'({bus.ch_fresh, bus.ovf_global_sticky, bus.ovf_rtc_sticky}), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Clean frame on channel 3
        push(1'b1, 1'b0, 1'b0, 16'hA5C3, 4'd3);
        drive_bits(4'd3, 16'hA5C3, 16, 1'b0);
        @(posedge clk);
        #1;
        check("wv_latency", 32'(bus.word_valid), 32'h1);
        idle(2);
        read_bank(3'd2, 16'hA5C3, "bank_ch3");
        check("fresh_ch3", 32'(bus.ch_fresh), 32'h04);

        // Short frame: sl_in drops after 9 bits
        push(1'b0, 1'b1, 1'b0, '0, 4'd0);
        drive_bits(4'd3, 16'hFFFF, 9, 1'b0);
        idle(3);
        read_bank(3'd2, 16'hA5C3, "bank_after_short");

        // 18 bits: word then a single overrun pulse
        push(1'b1, 1'b0, 1'b0, 16'h1234, 4'd7);
        push(1'b0, 1'b0, 1'b1, '0, 4'd0);
        drive_bits(4'd7, 16'h1234, 18, 1'b0);
        idle(3);
        read_bank(3'd6, 16'h1234, "bank_ch7");
        check("fresh_ch3_ch7", 32'(bus.ch_fresh), 32'h44);

        // Address changes 5 -> 6 on bit 4
        push(1'b0, 1'b1, 1'b0, '0, 4'd0);
        drive_bits(4'd5, 16'h0F0F, 3, 1'b0);
        drive_bits(4'd6, 16'h0F0F, 1, 1'b0);
        idle(3);
        check("fresh_after_addr_glitch", 32'(bus.ch_fresh), 32'h44);

        // Address 0: word published, frame_err with it, bank untouched
        push(1'b1, 1'b1, 1'b0, 16'h0001, 4'd0);
        drive_bits(4'd0, 16'h0001, 16, 1'b0);
        idle(3);
        check("fresh_after_addr0", 32'(bus.ch_fresh), 32'h44);
        read_bank(3'd0, 16'h0000, "bank_ch1_untouched");
        read_bank(3'd2, 16'hA5C3, "bank_ch3_after_addr0");

        // Sticky overflow flags and clear
        @(negedge clk);
        bus.ovf_rtc_in = 1'b1;
        @(negedge clk);
        bus.ovf_rtc_in = 1'b0;
        idle(2);
        #1;
        check("rtc_sticky_set", 32'({bus.ovf_global_sticky, bus.ovf_rtc_sticky}), 32'h1);
        @(negedge clk);
        bus.clr_fresh = 1'b1;
        @(negedge clk);
        bus.clr_fresh = 1'b0;
        #1;
        check("rtc_sticky_clr", 32'(bus.ovf_rtc_sticky), 32'h0);
        check("fresh_clr", 32'(bus.ch_fresh), 32'h0);
        @(negedge clk);
        bus.ovf_global_in = 1'b1;
        bus.clr_fresh     = 1'b1;
        @(negedge clk);
        bus.ovf_global_in = 1'b0;
        bus.clr_fresh     = 1'b0;
        #1;
        check("global_set_beats_clr", 32'(bus.ovf_global_sticky), 32'h1);

        // Channel NUM_CH with clr_fresh on the final bit: set wins
        push(1'b1, 1'b0, 1'b0, 16'hBEEF, 4'd8);
        drive_bits(4'd8, 16'hBEEF, 16, 1'b1);
        idle(3);
        check("fresh_set_beats_clr", 32'(bus.ch_fresh), 32'h80);
        read_bank(3'd7, 16'hBEEF, "bank_ch8");

        // Address above NUM_CH
        push(1'b1, 1'b1, 1'b0, 16'hFFFF, 4'd9);
        drive_bits(4'd9, 16'hFFFF, 16, 1'b0);
        idle(3);
        check("fresh_after_addr9", 32'(bus.ch_fresh), 32'h80);

        // Asynchronous reset during bit 7 of a frame
        drive_bits(4'd2, 16'h5555, 7, 1'b0);
        #2;
        reset     = 1'b1;
        bus.sl_in = 1'b0;
        #1;
        check("async_rst_word", 32'({bus.word_out, bus.ch_out}), 32'h0);
        check("async_rst_flags", 32'({bus.ch_fresh, bus.ovf_global_sticky, bus.ovf_rtc_sticky}), 32'h0);
        bus.rd_ch = 3'd7;
        #1;
        check("async_rst_bank", 32'(bus.rd_data), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle(2);

        push(1'b1, 1'b0, 1'b0, 16'h8001, 4'd1);
        drive_bits(4'd1, 16'h8001, 16, 1'b0);
        idle(3);
        read_bank(3'd0, 16'h8001, "bank_ch1_post_reset");
        check("fresh_post_reset", 32'(bus.ch_fresh), 32'h01);

        idle(4);
        check("all_events_seen", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
